// File: rtl/apb_master_bridge_if.sv
// ---------------------------------------------------------------------------
// apb_master_bridge_if
// Bundles the request/response handshake and the APB3 master-side bus of
// apb_master_bridge into one interface.
//
// Parameters
//   DATA_WIDTH : width of write/read data
//   ADDR_WIDTH : width of the transfer address
//
// Signals
//   req_valid / req_ready / req_write / req_addr / req_wdata : request port
//   rsp_valid / rsp_rdata / rsp_err                         : response port
//   PADDR / PSEL / PENABLE / PWRITE / PWDATA                 : APB3 outputs
//   PREADY / PRDATA                                          : APB3 inputs
//
// Modports
//   master : bridge view (drives req_ready, rsp_*, PADDR..PWDATA)
//   slave  : environment view (drives req_*, PREADY, PRDATA)
// ---------------------------------------------------------------------------
interface apb_master_bridge_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;

  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;

  logic [ADDR_WIDTH-1:0] PADDR;
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic                  PREADY;
  logic [DATA_WIDTH-1:0] PRDATA;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, PREADY, PRDATA,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, PREADY, PRDATA,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA
  );
endinterface

// File: rtl/apb_master_bridge.sv
// ---------------------------------------------------------------------------
// apb_master_bridge
// APB3 initiator: turns a valid/ready request into an APB3 SETUP/ACCESS
// transfer and returns a single-cycle response pulse when it completes.
//
// Ports
//   PCLK   : bus clock, all logic on the rising edge
//   PRESET : asynchronous, active-high reset
//   bus    : apb_master_bridge_if.master (request, response and APB3 bus)
//
// Configuration macro
//   APB_TIMEOUT_EN : when defined, an ACCESS phase that sees PREADY low for
//                    TIMEOUT_CYCLES cycles is aborted with rsp_err=1.
//                    When undefined, ACCESS waits forever and rsp_err=0.
// ---------------------------------------------------------------------------
module apb_master_bridge #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input logic                 PCLK,
  input logic                 PRESET,
  apb_master_bridge_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic                  pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

  logic accept_s;
  logic done_s;
  logic timeout_s;

  // A zero limit is meaningless: every wait state would abort at once.
  if (TIMEOUT_CYCLES == 32'd0) begin : g_illegal_timeout_cycles
  end

  assign accept_s = (state_q == S_IDLE) && bus.req_valid;
  assign done_s   = (state_q == S_ACCESS) && bus.PREADY;

`ifdef APB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 32'd1);

  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

  // The limit is hit on the wait cycle that would bring the count to
  // TIMEOUT_CYCLES; PREADY=1 in that cycle takes priority.
  assign timeout_s = (state_q == S_ACCESS) && !bus.PREADY &&
                     (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 32'd1));

  // Wait-state counter: zero outside ACCESS, so it is clear on ACCESS entry.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q != S_ACCESS) begin
      tmo_cnt_d = '0;
    end else if (!bus.PREADY) begin
      tmo_cnt_d = tmo_cnt_q + CNT_W'(1'b1);
    end else begin
      tmo_cnt_d = tmo_cnt_q;
    end
  end

  // Wait-state counter register.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          state_d = S_SETUP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETUP: begin
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        if (bus.PREADY || timeout_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_ACCESS;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode: next values of the registered outputs follow the next state.
  always_comb begin
    psel_d      = (state_d == S_SETUP) || (state_d == S_ACCESS);
    penable_d   = (state_d == S_ACCESS);
    rsp_valid_d = (state_q == S_ACCESS) && (state_d == S_IDLE);
    // timeout_s already implies PREADY=0, so a PREADY win reports no error.
    rsp_err_d   = timeout_s;
    if (accept_s) begin
      paddr_d  = bus.req_addr;
      pwrite_d = bus.req_write;
      pwdata_d = bus.req_wdata;
    end else begin
      paddr_d  = paddr_q;
      pwrite_d = pwrite_q;
      pwdata_d = pwdata_q;
    end
    // Only a completed read updates the read-data holding register.
    if (done_s && !pwrite_q) begin
      rsp_rdata_d = bus.PRDATA;
    end else begin
      rsp_rdata_d = rsp_rdata_q;
    end
  end

  // Output registers.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.PSEL      = psel_q;
  assign bus.PENABLE   = penable_q;
  assign bus.PADDR     = paddr_q;
  assign bus.PWRITE    = pwrite_q;
  assign bus.PWDATA    = pwdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// ---------------------------------------------------------------------------
// tb_apb_master_bridge
// Self-checking bench for apb_master_bridge (TIMEOUT_CYCLES = 4).
// Inputs are driven and outputs sampled on the falling edge of PCLK.
// ---------------------------------------------------------------------------
module tb_apb_master_bridge;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] prdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_lat;
    int          exp_en;
  } vec_t;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          due;
  } sb_t;

  logic PCLK;
  logic PRESET;

  apb_master_bridge_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  apb_master_bridge #(
    .DATA_WIDTH    (32),
    .ADDR_WIDTH    (32),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .PCLK  (PCLK),
    .PRESET(PRESET),
    .bus   (bus)
  );

  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  sb_t  sb[$];

  // Slave model controls and expected bus attributes of the current transfer.
  int          cur_waits  = 0;
  logic [31:0] cur_prdata = 32'h0;
  logic [31:0] exp_addr   = 32'h0;
  logic        exp_write  = 1'b0;
  logic [31:0] exp_wdata  = 32'h0;
  int          acc_cnt    = 0;
  int          en_cnt     = 0;

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  always @(posedge PCLK) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // APB slave model: PREADY high outside ACCESS (must be ignored), and in
  // ACCESS after cur_waits wait states. PRDATA is junk unless PREADY=1.
  always @(negedge PCLK) begin
    if (bus.PSEL && bus.PENABLE) begin
      acc_cnt++;
      en_cnt++;
      chk("access_paddr",  bus.PADDR,         exp_addr);
      chk("access_pwrite", 32'(bus.PWRITE),   32'(exp_write));
      if (exp_write) chk("access_pwdata", bus.PWDATA, exp_wdata);
      bus.PREADY = (acc_cnt > cur_waits);
      bus.PRDATA = bus.PREADY ? cur_prdata : ~cur_prdata;
    end else begin
      acc_cnt    = 0;
      bus.PREADY = 1'b1;
      bus.PRDATA = 32'hBAD0_BAD0;
    end
  end

  // Response monitor: pops the scoreboard on each rsp_valid pulse.
  always @(negedge PCLK) begin
    sb_t e;
    if (!PRESET) begin
      if (sb.size() > 0 && sb[0].due < cyc) begin
        tests++;
        fails++;
        $display("FAIL rsp_missing: none by cycle %0d, expected at %0d", cyc, sb[0].due);
        void'(sb.pop_front());
      end
      if (bus.rsp_valid) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL rsp_unexpected: rsp_valid=1 at cycle %0d, expected none", cyc);
        end else begin
          e = sb.pop_front();
          chk("rsp_cycle", 32'(cyc),           32'(e.due));
          chk("rsp_err",   32'(bus.rsp_err),   32'(e.err));
          chk("rsp_rdata", bus.rsp_rdata,      e.rdata);
        end
      end
    end
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic set_slave(input vec_t v);
    cur_waits  = v.waits;
    cur_prdata = v.prdata;
    exp_addr   = v.addr;
    exp_write  = v.write;
    exp_wdata  = v.wdata;
    en_cnt     = 0;
  endtask

  task automatic drive_req(input vec_t v);
    bus.req_valid = 1'b1;
    bus.req_write = v.write;
    bus.req_addr  = v.addr;
    bus.req_wdata = v.wdata;
  endtask

  // Wait (bounded) for the cycle in which req_valid && req_ready holds.
  task automatic wait_ready(input string name, output bit ok);
    int n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge PCLK);
      n++;
    end
    ok = bus.req_ready;
    chk(name, 32'(bus.req_ready), 32'd1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge PCLK);
      n++;
    end
    chk("rsp_drain", 32'(sb.size()), 32'd0);
  endtask

  // Apply one vector: accept, check SETUP, wait for response, check ACCESS length.
  task automatic run_vec(input vec_t v);
    bit ok;
    drive_req(v);
    set_slave(v);
    wait_ready("accept", ok);
    if (ok) sb.push_back('{v.exp_err, v.exp_rdata, cyc + v.exp_lat});
    @(negedge PCLK);
    bus.req_valid = 1'b0;
    chk("setup_psel",    32'(bus.PSEL),    32'd1);
    chk("setup_penable", 32'(bus.PENABLE), 32'd0);
    chk("setup_paddr",   bus.PADDR,        v.addr);
    wait_drain();
    chk("penable_cycles", 32'(en_cnt), 32'(v.exp_en));
  endtask

  vec_t vecs[6];

  initial begin
    vec_t a;
    vec_t b;
    bit   ok;
    int   acc1;

    // write/addr/wdata/waits/prdata/err/rdata/lat/en
    vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 32'h0,         1'b0, 32'h0000_0000, 3, 1};
    vecs[1] = '{1'b0, 32'h0000_0020, 32'h0,         3, 32'h1234_5678, 1'b0, 32'h1234_5678, 6, 4};
    vecs[2] = '{1'b0, 32'h0000_0030, 32'h0,         1, 32'hA5A5_A5A5, 1'b0, 32'hA5A5_A5A5, 4, 2};
    vecs[3] = '{1'b1, 32'h0000_0040, 32'h0BAD_F00D, 2, 32'h0,         1'b0, 32'hA5A5_A5A5, 5, 3};
    vecs[4] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         0, 32'h5A5A_0001, 1'b0, 32'h5A5A_0001, 3, 1};
    vecs[5] = '{1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 0, 32'h0,         1'b0, 32'h5A5A_0001, 3, 1};

    PRESET        = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = 32'h0;
    bus.req_wdata = 32'h0;
    bus.PREADY    = 1'b1;
    bus.PRDATA    = 32'h0;

    // Reset state.
    repeat (2) @(negedge PCLK);
    chk("rst_psel",      32'(bus.PSEL),      32'd0);
    chk("rst_penable",   32'(bus.PENABLE),   32'd0);
    chk("rst_paddr",     bus.PADDR,          32'h0);
    chk("rst_pwrite",    32'(bus.PWRITE),    32'd0);
    chk("rst_pwdata",    bus.PWDATA,         32'h0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_err",   32'(bus.rsp_err),   32'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata,      32'h0);
    PRESET = 1'b0;
    @(negedge PCLK);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);

    // Table-driven single transfers.
    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i]);
      @(negedge PCLK);
    end
    chk("rdata_hold_idle", bus.rsp_rdata, 32'h5A5A_0001);

    // Back-to-back with req_valid held: second accepted in first's rsp cycle.
    a = '{1'b1, 32'h0000_0100, 32'h1111_2222, 0, 32'h0,         1'b0, 32'h5A5A_0001, 3, 1};
    b = '{1'b0, 32'h0000_0104, 32'h0,         0, 32'h3333_4444, 1'b0, 32'h3333_4444, 3, 1};
    drive_req(a);
    set_slave(a);
    wait_ready("b2b_accept1", ok);
    if (ok) sb.push_back('{a.exp_err, a.exp_rdata, cyc + a.exp_lat});
    acc1 = cyc;
    @(negedge PCLK);
    drive_req(b);
    chk("b2b_setup1_psel", 32'(bus.PSEL), 32'd1);
    @(negedge PCLK);
    chk("b2b_access1_psel", 32'(bus.PSEL), 32'd1);
    wait_ready("b2b_accept2", ok);
    chk("b2b_accept2_cycle", 32'(cyc - acc1),    32'd3);
    chk("b2b_accept2_rsp",   32'(bus.rsp_valid), 32'd1);
    chk("b2b_gap_psel",      32'(bus.PSEL),      32'd0);
    if (ok) sb.push_back('{b.exp_err, b.exp_rdata, cyc + b.exp_lat});
    set_slave(b);
    @(negedge PCLK);
    bus.req_valid = 1'b0;
    chk("b2b_setup2_psel",    32'(bus.PSEL),    32'd1);
    chk("b2b_setup2_penable", 32'(bus.PENABLE), 32'd0);
    chk("b2b_setup2_paddr",   bus.PADDR,        32'h0000_0104);
    wait_drain();
    @(negedge PCLK);

    // Long wait: aborts at the limit with the timeout, otherwise waits it out.
`ifdef APB_TIMEOUT_EN
    a = '{1'b0, 32'h0000_0300, 32'h0, 1000, 32'hCAFE_0001, 1'b1, 32'h3333_4444, 6, 4};
`else
    a = '{1'b0, 32'h0000_0300, 32'h0, 20,   32'h6666_5555, 1'b0, 32'h6666_5555, 23, 21};
`endif
    run_vec(a);
    @(negedge PCLK);
    // PREADY rises in the 4th ACCESS cycle: normal completion either way.
    b = '{1'b0, 32'h0000_0304, 32'h0, 3, 32'h7777_8888, 1'b0, 32'h7777_8888, 6, 4};
    run_vec(b);
    @(negedge PCLK);

    // Reset in an ACCESS wait state: bus drops at once, no response.
    a = '{1'b0, 32'h0000_0200, 32'h0, 1000, 32'h9999_0000, 1'b0, 32'h0, 0, 0};
    drive_req(a);
    set_slave(a);
    wait_ready("rstx_accept", ok);
    @(negedge PCLK);
    bus.req_valid = 1'b0;
    repeat (2) @(negedge PCLK);
    chk("rstx_pre_penable", 32'(bus.PENABLE), 32'd1);
    #2 PRESET = 1'b1;
    #1;
    chk("rstx_psel",      32'(bus.PSEL),      32'd0);
    chk("rstx_penable",   32'(bus.PENABLE),   32'd0);
    chk("rstx_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    @(negedge PCLK);
    PRESET = 1'b0;
    chk("rstx_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rstx_rsp_rdata", bus.rsp_rdata,      32'h0);
    for (int i = 0; i < 5; i++) begin
      @(negedge PCLK);
      chk("rstx_no_rsp",  32'(bus.rsp_valid), 32'd0);
      chk("rstx_no_psel", 32'(bus.PSEL),      32'd0);
    end
    chk("sb_empty_end", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
